aes128_sched: RTL

- Shares one aes128 core between NUM_REQ requesters using round-robin arbitration.
- Sequences the core's key expansion (reset_key / key_ready) and data processing (load_data / cipher_ready).
- Caches the currently expanded key, so back-to-back jobs with the same key skip re-expansion.
- Returns each result, or a timeout error, to the requester that issued the job.

---
 rtl/aes128_sched.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aes128_sched.sv
// aes128_sched: shares one AES-128 core between NUM_REQ requesters.
//
// Jobs are granted round-robin while idle. The scheduler runs the core's key
// expansion only when the job key differs from the key the core currently
// holds, then loads the data block, waits for the result (or a timeout) and
// returns a one-cycle response to the requester that issued the job.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o per-requester handshake, ready is a one-hot grant
//   req_key_i/req_data_i    128-bit key/data per requester, slice r at [128r +: 128]
//   req_enc_i               1 = encrypt, 0 = decrypt
//   resp_valid_o            one-hot, one-cycle result pulse to the owner
//   resp_data_o/resp_err_o  result block and timeout flag, valid with resp_valid_o
//   core_*_o / core_*_i     connections to the shared aes128 core
module aes128_sched #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [128*NUM_REQ-1:0]   req_key_i,
  input  logic [128*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]       req_enc_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [127:0]             resp_data_o,
  output logic                     resp_err_o,
  output logic                     core_reset_key_o,
  output logic [127:0]             core_cipher_key_o,
  output logic                     core_load_data_o,
  output logic [127:0]             core_plain_text_o,
  output logic                     core_enc_or_dec_o,
  input  logic                     core_key_ready_i,
  input  logic                     core_cipher_ready_i,
  input  logic [127:0]             core_cipher_text_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, KEY_PULSE, KEY_WAIT, LOAD, RUN, RESP
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic                 key_valid_q;
  logic [127:0]         cached_key_q;
  logic [TMR_W-1:0]     timer_q;
  logic                 core_reset_key_q;
  logic                 core_load_data_q;
  logic [127:0]         core_cipher_key_q;
  logic [127:0]         core_plain_text_q;
  logic                 core_enc_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [127:0]         resp_data_q;
  logic                 resp_err_q;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  int                   cand_idx;
  logic [127:0]         sel_key;
  logic [127:0]         sel_data;
  logic                 sel_enc;
  logic                 accept;
  logic [NUM_REQ-1:0]   owner_onehot;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[IDX_W'(cand_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand_idx);
      end
    end
  end

  // Pick the granted requester's key, data and direction.
  always_comb begin
    sel_key  = '0;
    sel_data = '0;
    sel_enc  = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_idx == IDX_W'(r)) begin
        sel_key  = req_key_i[128*r +: 128];
        sel_data = req_data_i[128*r +: 128];
        sel_enc  = req_enc_i[r];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_found && rst_n_i;

  // Grant is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  assign owner_onehot = NUM_REQ'(1) << owner_q;

  // Main sequencer. core_reset_key_q / core_load_data_q are set on the edge
  // entering KEY_PULSE / LOAD so the pulses line up with those states.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q           <= IDLE;
      rr_ptr_q          <= IDX_W'(NUM_REQ - 1);
      owner_q           <= '0;
      key_valid_q       <= 1'b0;
      cached_key_q      <= '0;
      timer_q           <= '0;
      core_reset_key_q  <= 1'b0;
      core_load_data_q  <= 1'b0;
      core_cipher_key_q <= '0;
      core_plain_text_q <= '0;
      core_enc_q        <= 1'b0;
      resp_valid_q      <= '0;
      resp_data_q       <= '0;
      resp_err_q        <= 1'b0;
    end else begin
      core_reset_key_q <= 1'b0;
      core_load_data_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q           <= grant_idx;
            rr_ptr_q          <= grant_idx;
            core_cipher_key_q <= sel_key;
            core_plain_text_q <= sel_data;
            core_enc_q        <= sel_enc;
            if (key_valid_q && (sel_key == cached_key_q)) begin
              state_q          <= LOAD;
              core_load_data_q <= 1'b1;
            end else begin
              state_q          <= KEY_PULSE;
              core_reset_key_q <= 1'b1;
            end
          end
        end
        KEY_PULSE: begin
          cached_key_q <= core_cipher_key_q;
          key_valid_q  <= 1'b0;
          timer_q      <= '0;
          state_q      <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (core_key_ready_i) begin
            key_valid_q      <= 1'b1;
            core_load_data_q <= 1'b1;
            state_q          <= LOAD;
          end else if (timer_q == TMR_LAST) begin
            key_valid_q  <= 1'b0;
            resp_valid_q <= owner_onehot;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        LOAD: begin
          timer_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (core_cipher_ready_i) begin
            resp_valid_q <= owner_onehot;
            resp_data_q  <= core_cipher_text_i;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else if (timer_q == TMR_LAST) begin
            key_valid_q  <= 1'b0;
            resp_valid_q <= owner_onehot;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RESP: begin
          resp_valid_q <= '0;
          resp_data_q  <= '0;
          resp_err_q   <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign resp_err_o        = resp_err_q;
  assign core_reset_key_o  = core_reset_key_q;
  assign core_cipher_key_o = core_cipher_key_q;
  assign core_load_data_o  = core_load_data_q;
  assign core_plain_text_o = core_plain_text_q;
  assign core_enc_or_dec_o = core_enc_q;

endmodule
